dmux8_rr_arbiter: RTL and testbench



---
 rtl/dmux8_rr_arbiter_pkg.sv | 19 +
 rtl/dmux8_rr_arbiter_rr_pick8.sv | 30 +++
 rtl/dmux8_rr_arbiter.sv | 83 ++++++++
 tb/tb_dmux8_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and its pick logic.
package dmux8_rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dmux8_rr_arbiter_rr_pick8.sv
// Rotating-priority encoder: first set request bit after 'last', wrapping 7 -> 0.
module rr_pick8
  import dmux8_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  // Offset 8 wraps back to 'last' itself, so the previous owner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dmux8_rr_arbiter.sv
// Round-robin arbiter sharing one DMux8Way-selected resource among 8 requesters,
// with owner release, request withdrawal and a hold watchdog.
module dmux8_rr_arbiter
  import dmux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout
);

  // Handshake: a requester holds req[i] high until served; the owner keeps req
  // high while using the resource and ends ownership with done=1 or by dropping
  // req. Each grant is followed by exactly one idle arbitration cycle.

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick_winner;
  logic             pick_any;
  logic             rel_wd;
  logic             rel_any;

  rr_pick8 u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign rel_wd  = (cnt == CNT_W'(MAX_HOLD - 1));
  assign rel_any = done || !req[sel] || rel_wd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= SEL_W'(NUM_REQ - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state <= ST_GRANT;
            grant <= onehot8(pick_winner);
            sel   <= pick_winner;
            busy  <= 1'b1;
            cnt   <= '0;
            last  <= pick_winner;
          end
        end
        ST_GRANT: begin
          if (rel_any) begin
            state   <= ST_IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            // Only a pure watchdog expiry counts as a forced release.
            timeout <= rel_wd && !done && req[sel];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmux8_rr_arbiter.sv
// Self-checking bench for dmux8_rr_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_dmux8_rr_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic       m_busy;
  logic [2:0] m_sel;
  logic [2:0] m_last;
  logic       m_timeout;
  int         m_held;

  logic [2:0] exp_q[$];

  dmux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Winner = requesting index with the smallest rotational distance past 'last'.
  task automatic model_edge();
    int best_d;
    int best_i;
    int d;
    logic wd;
    if (reset) begin
      m_busy = 0; m_sel = 0; m_last = 7; m_timeout = 0; m_held = 0;
    end else if (!m_busy) begin
      m_timeout = 0;
      if (req != 8'h00) begin
        best_d = 99; best_i = 0;
        for (int i = 0; i < 8; i++) begin
          d = (i - int'(m_last) + 15) % 8;
          if (req[i] && d < best_d) begin best_d = d; best_i = i; end
        end
        m_busy = 1; m_sel = 3'(best_i); m_last = 3'(best_i); m_held = 1;
      end
    end else begin
      wd = (m_held == MAX_HOLD);
      if (done || !req[m_sel] || wd) begin
        m_busy = 0;
        m_timeout = wd && !done && req[m_sel];
      end else begin
        m_held++;
        m_timeout = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; req = 8'h00; done = 0;
    tick(); tick();
    n_checks++;
    if ({grant, sel, busy, timeout} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset: grant=%h sel=%0d busy=%b timeout=%b, want all zero", grant, sel, busy, timeout);
    end
    reset = 0;
  endtask

  task automatic test_single();
    req = 8'h01; tick();
    n_checks++;
    if ({grant, sel, busy} !== {8'h01, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL single_grant: grant=%h sel=%0d busy=%b, want 01 0 1", grant, sel, busy);
    end
    done = 1; tick();
    n_checks++;
    if ({grant, sel, busy, timeout} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_release: grant=%h sel=%0d busy=%b timeout=%b, want 00 0 0 0", grant, sel, busy, timeout);
    end
    done = 0; req = 8'h00; tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    exp_q.push_back(3'd0);
    req = 8'hFF;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      n_checks++;
      if (!busy || sel !== e || grant !== (8'h01 << e)) begin
        n_fail++; $display("FAIL rr_order: busy=%b sel=%0d grant=%h, want sel=%0d", busy, sel, grant, e);
      end
      done = 1; tick(); done = 0;
      n_checks++;
      if (busy !== 1'b0 || grant !== 8'h00) begin
        n_fail++; $display("FAIL rr_bubble: busy=%b grant=%h, want idle", busy, grant);
      end
    end
    req = 8'h00; tick();
  endtask

  task automatic test_wrap_skip();
    reset = 1; tick(); reset = 0;
    req = 8'h20; tick();
    req = 8'h00; tick();
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd5);
    req = 8'b0010_0011;
    while (exp_q.size() > 0) begin
      tick();
      n_checks++;
      if (!busy || sel !== exp_q[0]) begin
        n_fail++; $display("FAIL wrap_skip: busy=%b sel=%0d, want sel=%0d", busy, sel, exp_q[0]);
      end
      void'(exp_q.pop_front());
      done = 1; tick(); done = 0;
    end
    req = 8'h00; tick();
  endtask

  task automatic test_watchdog();
    int hold;
    reset = 1; tick(); reset = 0;
    req = 8'h18; tick();
    n_checks++;
    if (sel !== 3'd3 || grant !== 8'h08) begin
      n_fail++; $display("FAIL wd_owner: sel=%0d grant=%h, want 3 08", sel, grant);
    end
    hold = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      hold++;
    end
    n_checks++;
    if (hold != MAX_HOLD || timeout !== 1'b1 || grant !== 8'h00) begin
      n_fail++; $display("FAIL wd_expire: held=%0d timeout=%b grant=%h, want %0d 1 00", hold, timeout, grant, MAX_HOLD);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0 || sel !== 3'd4 || grant !== 8'h10) begin
      n_fail++; $display("FAIL wd_next: timeout=%b sel=%0d grant=%h, want 0 4 10", timeout, sel, grant);
    end
    req = 8'h00; tick(); tick();
  endtask

  task automatic test_withdraw_reset();
    reset = 1; tick(); reset = 0;
    req = 8'h04; tick();
    req = 8'h00; tick();
    n_checks++;
    if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL withdraw: grant=%h busy=%b timeout=%b, want 00 0 0", grant, busy, timeout);
    end
    req = 8'h01; tick();
    reset = 1; tick(); reset = 0;
    n_checks++;
    if ({grant, sel, busy} !== {8'h00, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: grant=%h sel=%0d busy=%b, want 00 0 0", grant, sel, busy);
    end
    req = 8'h80; tick();
    n_checks++;
    if (sel !== 3'd7 || grant !== 8'h80) begin
      n_fail++; $display("FAIL ptr_restart: sel=%0d grant=%h, want 7 80", sel, grant);
    end
    req = 8'h00; tick(); tick();
  endtask

  task automatic test_done_collision();
    reset = 1; tick(); reset = 0;
    req = 8'h01; tick();
    for (int i = 0; i < MAX_HOLD - 1; i++) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL collide_hold: busy=%b, want 1", busy);
    end
    done = 1; tick();
    n_checks++;
    if (grant !== 8'h00 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL collide_release: grant=%h timeout=%b, want 00 0", grant, timeout);
    end
    req = 8'h02; tick();
    n_checks++;
    if (sel !== 3'd1 || grant !== 8'h02) begin
      n_fail++; $display("FAIL idle_done: sel=%0d grant=%h, want 1 02", sel, grant);
    end
    req = 8'h00; done = 0; tick(); tick();
  endtask

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      n_checks++;
      if (grant !== (m_busy ? (8'h01 << m_sel) : 8'h00) || busy !== m_busy
          || sel !== m_sel || timeout !== m_timeout) begin
        n_fail++;
        $display("FAIL random c=%0d: grant=%h sel=%0d busy=%b timeout=%b, want busy=%b sel=%0d timeout=%b",
                 c, grant, sel, busy, timeout, m_busy, m_sel, m_timeout);
      end
      n_checks++;
      if (!$onehot0(grant) || busy !== (|grant) || (busy && grant !== (8'h01 << sel))) begin
        n_fail++; $display("FAIL invariant c=%0d: grant=%h sel=%0d busy=%b", c, grant, sel, busy);
      end
    end
    reset = 0; req = 8'h00; done = 0; tick(); tick();
  endtask

  initial begin
    reset = 1; req = 8'h00; done = 0;
    m_busy = 0; m_sel = 0; m_last = 7; m_timeout = 0; m_held = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_watchdog();
    test_withdraw_reset();
    test_done_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
